// File: rtl/clint_pkg.sv
// clint_pkg: shared register offsets, widths and byte-merge helper for the CLINT
package clint_pkg;

    localparam int MTIME_W = 64;

    localparam logic [15:0] OFF_MSIP        = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        return merged;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk into one mtime tick every PRESCALE cycles
module clint_prescaler #(
    parameter int PRESCALE = 1
)(
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [15:0] count;

    assign tick = (count == 16'(PRESCALE - 1));

    // count 0..PRESCALE-1, wrapping on the tick cycle
    always_ff @(posedge clk) begin
        if (!reset) count <= '0;
        else        count <= tick ? '0 : count + 16'd1;
    end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor (msip, mtime, mtimecmp); CLINT_MTIME_HI_LATCH_EN adds a torn-free mtime hi shadow
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [31:0]        BASE_ADDR    = 32'h0200_0000,
    parameter int                 PRESCALE     = 1,
    parameter logic [MTIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        Sel,
    input  logic [3:0]  MemWrite_EN,
    input  logic [31:0] MemAddr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Timer_Int,
    output logic        Sw_Int
);

    logic [15:0]        off;
    logic               wr, rd, tick;
    logic               wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mt_lo, wr_mt_hi;
    logic [MTIME_W-1:0] mtime, mtime_nxt, mtimecmp;
    logic               msip;
    logic [31:0]        mtime_hi_rd, rd_data;
    logic               unused;

    assign off       = {MemAddr[15:2], 2'b00};
    assign wr        = Sel & (|MemWrite_EN);
    assign rd        = Sel & ~(|MemWrite_EN);
    assign wr_msip   = wr & (off == OFF_MSIP);
    assign wr_cmp_lo = wr & (off == OFF_MTIMECMP_LO);
    assign wr_cmp_hi = wr & (off == OFF_MTIMECMP_HI);
    assign wr_mt_lo  = wr & (off == OFF_MTIME_LO);
    assign wr_mt_hi  = wr & (off == OFF_MTIME_HI);

    // the fabric has already decoded the region, so the base and the upper address bits are don't-cares here
    assign unused = ^{BASE_ADDR, MemAddr[31:16], MemAddr[1:0]};

    clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // next mtime: a write to either half replaces that word and freezes the count for the cycle
    always_comb begin
        mtime_nxt = tick ? mtime + 64'd1 : mtime;
        if (wr_mt_lo) mtime_nxt = {mtime[63:32], byte_merge(mtime[31:0], WriteData, MemWrite_EN)};
        if (wr_mt_hi) mtime_nxt = {byte_merge(mtime[63:32], WriteData, MemWrite_EN), mtime[31:0]};
    end

    assign rd_data = (off == OFF_MSIP)        ? {31'b0, msip}   :
                     (off == OFF_MTIMECMP_LO) ? mtimecmp[31:0]  :
                     (off == OFF_MTIMECMP_HI) ? mtimecmp[63:32] :
                     (off == OFF_MTIME_LO)    ? mtime[31:0]     :
                     (off == OFF_MTIME_HI)    ? mtime_hi_rd     : 32'b0;

    // register file, registered read port and interrupt flops
    always_ff @(posedge clk) begin
        if (!reset) begin
            mtime     <= '0;
            mtimecmp  <= MTIMECMP_RST;
            msip      <= 1'b0;
            ReadData  <= '0;
            Timer_Int <= 1'b0;
            Sw_Int    <= 1'b0;
        end else begin
            mtime <= mtime_nxt;
            if (wr_cmp_lo) mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], WriteData, MemWrite_EN);
            if (wr_cmp_hi) mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], WriteData, MemWrite_EN);
            if (wr_msip && MemWrite_EN[0]) msip <= WriteData[0];
            if (rd) ReadData <= rd_data;
            Timer_Int <= (mtime >= mtimecmp);
            Sw_Int    <= msip;
        end
    end

`ifdef CLINT_MTIME_HI_LATCH_EN
    logic [31:0] mtime_hi_shadow;

    // a lo read snapshots hi so the following hi read matches it; a hi write keeps the snapshot coherent
    always_ff @(posedge clk) begin
        if (!reset)                         mtime_hi_shadow <= '0;
        else if (wr_mt_hi)                  mtime_hi_shadow <= mtime_nxt[63:32];
        else if (rd && off == OFF_MTIME_LO) mtime_hi_shadow <= mtime[63:32];
    end

    assign mtime_hi_rd = mtime_hi_shadow;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped core-local interruptor. It is the responder on the core's Dmem port and the source of the core's Timer_Int and Sw_Int inputs.
- Holds a free-running 64-bit mtime, a 64-bit mtimecmp and a 1-bit msip.
- The bus fabric decodes the region and asserts Sel. This block decodes offsets within the region.
- ReadData returns one cycle after the address, matching the pipelined data-memory timing.

Parameters:
- BASE_ADDR, 32'h0200_0000, region base; only MemAddr[15:0] is decoded, upper bits ignored.
- PRESCALE, 1, clk cycles per mtime tick; legal range 1..65535.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, mtimecmp reset value.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- Sel  in  1  region select from fabric decode
- MemWrite_EN  in  4  byte write enables; 4'b0000 with Sel high = read
- MemAddr  in  32  byte address; [1:0] ignored (word access only)
- WriteData  in  32  store data
- ReadData  out  32  registered read data
- Timer_Int  out  1  machine timer interrupt pending
- Sw_Int  out  1  machine software interrupt pending

Behaviour:
- Register map (offset = MemAddr[15:0] & ~3):
  - 0x0000 msip: bit0 is R/W, bits 31:1 read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - All other offsets: reads return 0, writes are dropped.
- Reset: mtime=0, mtimecmp=MTIMECMP_RST, msip=0, prescaler count=0, ReadData=0, Timer_Int=0, Sw_Int=0.
- Writes (Sel & |MemWrite_EN):
  - Byte-merge: byte i is updated iff MemWrite_EN[i].
  - Take effect at the clk edge; new value is visible to a read issued the next cycle.
- Reads (Sel & MemWrite_EN==0):
  - ReadData updated at the clk edge to the value of the addressed register as it was before that edge. Valid the cycle after the request.
  - ReadData holds its last value when there is no read.
- Writes do not update ReadData.
- Prescaler:
  - Counter 0..PRESCALE-1; tick asserted when count==PRESCALE-1, then count wraps to 0.
  - PRESCALE==1 means tick every cycle.
- mtime:
  - Increments by 1 on tick with full 64-bit carry. Wraps from 2^64-1 to 0.
- Write to an mtime half in the same cycle as a tick:
  - The write wins for the written word.
  - The increment is suppressed for the whole 64-bit value that cycle, so there is no carry into or out of the written word.
  - The prescaler still advances.
- Timer_Int: registered, = (mtime >= mtimecmp) using the post-edge values, unsigned 64-bit compare. Updates one cycle after any change of mtime or mtimecmp.
- Sw_Int: registered copy of msip, asserted the cycle after the write edge.
- Sel low: no register access, ReadData holds.
- Reset mid-operation: all state returns to reset values on that edge, including any in-flight read result.
- Software idiom (must work): write mtimecmp hi=0xFFFFFFFF, then lo, then hi. This avoids a spurious Timer_Int.

Optional Feature:
- Macro: CLINT_MTIME_HI_LATCH_EN.
- Defined:
  - A read of mtime lo (0xBFF8) also captures mtime[63:32] into a shadow register.
  - A read of 0xBFFC returns the shadow, giving a torn-free 64-bit read as lo then hi.
  - Shadow resets to 0.
  - A write to 0xBFFC updates both mtime hi and the shadow.
- Undefined: 0xBFFC returns live mtime[63:32]; no shadow register exists.

Decomposition:
- Shared package clint_pkg:
  - offset localparams OFF_MSIP, OFF_MTIMECMP_LO/HI, OFF_MTIME_LO/HI;
  - a byte-merge function (old, new, be) -> merged;
  - MTIME_W=64.
- One natural sub-module: clint_prescaler (tick generator). Ports: clk, reset, tick; parameter PRESCALE.

Test Plan:
1. Reset with reset=0 for 2 cycles, then release with PRESCALE=1 → ReadData=0, Timer_Int=0, Sw_Int=0. After 10 cycles, a read of 0xBFF8 returns 10 ± the fixed read-latency offset, checked against a reference model.
2. Write 0x0000 with data 1 and EN=4'b0001 → Sw_Int=1 the next cycle. Then write data 0 → Sw_Int=0 the next cycle. A read of 0x0000 after the first write returns 32'h1.
3. Set mtimecmp={0,20} with mtime reset → Timer_Int rises exactly the cycle after mtime reaches 20. Writing mtimecmp lo=0xFFFFFFFF clears it one cycle later.
4. Byte-enable merge: mtimecmp lo=0x11223344, then write 0xAABBCCDD with EN=4'b0101 → read returns 0x11BB33DD.
5. Carry/wrap: write mtime hi=0, lo=0xFFFFFFFF, PRESCALE=1 → next tick gives hi=1, lo=0. Also set mtime={0xFFFFFFFF,0xFFFFFFFF} → wraps to 0 and Timer_Int drops when mtimecmp=1.
6. PRESCALE=4 with a write to mtime lo coinciding with a tick → the written value is held, no increment that cycle, and the next increment comes 4 cycles later. With CLINT_MTIME_HI_LATCH_EN, a lo read at 0x00000001_FFFFFFFF followed by a hi read after a carry returns hi=1 (the shadow), not 2.
